// File: rtl/jt12_cmd_seq.sv
// jt12_cmd_seq: command FIFO plus bus sequencer for a YM2612-style chip.
// Commands are queued at full clk rate and played out on the chip bus at
// the cen rate: FM register writes (with busy polling), PSG writes, and
// sample-count waits paced by the chip sample strobe.
`timescale 1ns/1ps
module jt12_cmd_seq #(
  parameter int AW      = 4,
  parameter int WR_CYC  = 2,
  parameter int BUSY_TO = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [18:0] cmd_data,
  output logic [7:0]  din,
  output logic [1:0]  addr,
  output logic        cs_n,
  output logic        wr_n,
  output logic        psg_wr_n,
  input  logic [7:0]  dout,
  input  logic        snd_sample,
  output logic        idle,
  output logic        timeout,
  output logic [AW:0] level
);

  localparam int DEPTH = 1 << AW;
  localparam int CW    = (WR_CYC > 1) ? $clog2(WR_CYC) : 1;
  localparam int PW    = (BUSY_TO > 1) ? $clog2(BUSY_TO) : 1;
  localparam logic [CW-1:0] WR_LAST   = CW'(WR_CYC - 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(BUSY_TO - 1);

  localparam logic [1:0] OP_FM   = 2'b00;
  localparam logic [1:0] OP_PSG  = 2'b01;
  localparam logic [1:0] OP_WAIT = 2'b10;

  localparam logic [3:0] ST_IDLE = 4'd0;
  localparam logic [3:0] ST_POLL = 4'd1;
  localparam logic [3:0] ST_AWR  = 4'd2;
  localparam logic [3:0] ST_AREL = 4'd3;
  localparam logic [3:0] ST_DWR  = 4'd4;
  localparam logic [3:0] ST_DREL = 4'd5;
  localparam logic [3:0] ST_PWR  = 4'd6;
  localparam logic [3:0] ST_PREL = 4'd7;
  localparam logic [3:0] ST_WAIT = 4'd8;

  // FIFO storage and pointers
  logic [18:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;

  // Sequencer state
  logic [3:0]    r_state;
  logic [CW-1:0] r_wcnt;
  logic [PW-1:0] r_poll_cnt;
  logic [15:0]   r_wait_cnt;
  logic          r_part;
  logic [7:0]    r_reg;
  logic [7:0]    r_val;
  logic          r_timeout;
  logic          r_cs_n;
  logic          r_wr_n;
  logic          r_psg_wr_n;
  logic [7:0]    r_din;
  logic [1:0]    r_addr;

  // Sample strobe edge detection
  logic          r_snd_d;
  logic          r_edge_pend;

  logic [18:0]   w_head;
  logic [1:0]    w_op;
  logic          w_push;
  logic          w_pop;
  logic          w_snd_rise;
  logic          w_poll_expire;
  logic          w_part_n;
  logic [7:0]    w_reg_n;
  logic [7:0]    w_val_n;
  logic [3:0]    w_state_next;
  logic          w_cs_n_next;
  logic          w_wr_n_next;
  logic          w_psg_wr_n_next;
  logic [7:0]    w_din_next;
  logic [1:0]    w_addr_next;
  logic          w_unused;

  // Only the busy flag of the status byte matters here.
  assign w_unused = ^dout[6:0];

  // The head entry is read asynchronously: the pop decision and the next
  // bus values depend on it in the same cycle.
  assign w_head     = r_mem[r_rd_ptr];
  assign w_op       = w_head[18:17];
  assign cmd_ready  = !rst && !r_level[AW];
  assign w_push     = cmd_valid && cmd_ready;
  assign w_pop      = cen && (r_state == ST_IDLE) && (r_level != '0);
  assign w_snd_rise = snd_sample && !r_snd_d;
  assign w_poll_expire = dout[7] && (r_poll_cnt == POLL_LAST);

  // Fields of the command in flight, including the one being popped now.
  assign w_part_n = w_pop ? w_head[16]   : r_part;
  assign w_reg_n  = w_pop ? w_head[15:8] : r_reg;
  assign w_val_n  = w_pop ? w_head[7:0]  : r_val;

  // FIFO storage write; no reset needed on the data array.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= cmd_data;
    end
  end

  // FIFO pointers and occupancy; push is independent of cen.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      r_level <= r_level + (AW+1)'(1);
      else if (!w_push && w_pop) r_level <= r_level - (AW+1)'(1);
    end
  end

  // Sample strobe rising edges are caught every clk and held until a cen.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_snd_d     <= 1'b0;
      r_edge_pend <= 1'b0;
    end else begin
      r_snd_d     <= snd_sample;
      r_edge_pend <= w_snd_rise || (r_edge_pend && !cen);
    end
  end

  // Next-state logic of the bus sequencer.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_pop) begin
          case (w_op)
            OP_FM:   w_state_next = ST_POLL;
            OP_PSG:  w_state_next = ST_PWR;
            OP_WAIT: w_state_next = (w_head[15:0] == 16'd0) ? ST_IDLE : ST_WAIT;
            default: w_state_next = ST_IDLE;
          endcase
        end
      end
      ST_POLL: if (!dout[7] || w_poll_expire) w_state_next = ST_AWR;
      ST_AWR:  if (r_wcnt == WR_LAST) w_state_next = ST_AREL;
      ST_AREL: w_state_next = ST_DWR;
      ST_DWR:  if (r_wcnt == WR_LAST) w_state_next = ST_DREL;
      ST_DREL: w_state_next = ST_IDLE;
      ST_PWR:  if (r_wcnt == WR_LAST) w_state_next = ST_PREL;
      ST_PREL: w_state_next = ST_IDLE;
      ST_WAIT: if (r_edge_pend && (r_wait_cnt == 16'd1)) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Bus values for the state being entered; din/addr hold unless driven.
  always_comb begin
    w_cs_n_next     = 1'b1;
    w_wr_n_next     = 1'b1;
    w_psg_wr_n_next = 1'b1;
    w_din_next      = r_din;
    w_addr_next     = r_addr;
    case (w_state_next)
      ST_POLL: begin
        w_cs_n_next = 1'b0;
        w_addr_next = 2'b00;
      end
      ST_AWR: begin
        w_cs_n_next = 1'b0;
        w_wr_n_next = 1'b0;
        w_addr_next = {w_part_n, 1'b0};
        w_din_next  = w_reg_n;
      end
      ST_DWR: begin
        w_cs_n_next = 1'b0;
        w_wr_n_next = 1'b0;
        w_addr_next = {w_part_n, 1'b1};
        w_din_next  = w_val_n;
      end
      ST_PWR: begin
        w_psg_wr_n_next = 1'b0;
        w_din_next      = w_val_n;
      end
      default: ;
    endcase
  end

  // Sequencer registers advance only on cen; reset wins regardless of cen.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_wcnt     <= '0;
      r_poll_cnt <= '0;
      r_wait_cnt <= '0;
      r_part     <= 1'b0;
      r_reg      <= '0;
      r_val      <= '0;
      r_timeout  <= 1'b0;
      r_cs_n     <= 1'b1;
      r_wr_n     <= 1'b1;
      r_psg_wr_n <= 1'b1;
      r_din      <= '0;
      r_addr     <= '0;
    end else if (cen) begin
      r_state    <= w_state_next;
      r_cs_n     <= w_cs_n_next;
      r_wr_n     <= w_wr_n_next;
      r_psg_wr_n <= w_psg_wr_n_next;
      r_din      <= w_din_next;
      r_addr     <= w_addr_next;
      r_part     <= w_part_n;
      r_reg      <= w_reg_n;
      r_val      <= w_val_n;

      if (w_pop && (w_op == OP_WAIT)) begin
        r_wait_cnt <= w_head[15:0];
      end else if ((r_state == ST_WAIT) && r_edge_pend) begin
        r_wait_cnt <= r_wait_cnt - 16'd1;
      end

      // Strobe-length counter restarts on every state change.
      if (((r_state == ST_AWR) || (r_state == ST_DWR) || (r_state == ST_PWR)) &&
          (w_state_next == r_state)) begin
        r_wcnt <= r_wcnt + CW'(1);
      end else begin
        r_wcnt <= '0;
      end

      if ((r_state == ST_POLL) && (w_state_next == ST_POLL)) begin
        r_poll_cnt <= r_poll_cnt + PW'(1);
      end else begin
        r_poll_cnt <= '0;
      end

      // Giving up on busy is remembered until reset.
      if ((r_state == ST_POLL) && w_poll_expire) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign din      = r_din;
  assign addr     = r_addr;
  assign cs_n     = r_cs_n;
  assign wr_n     = r_wr_n;
  assign psg_wr_n = r_psg_wr_n;
  assign timeout  = r_timeout;
  assign level    = r_level;
  assign idle     = (r_state == ST_IDLE) && (r_level == '0);

endmodule

// File: tb/tb_jt12_cmd_seq.sv
// Directed testbench for jt12_cmd_seq: FM/PSG writes, busy polling and
// timeout, WAIT pacing, FIFO limits and reset during a write.
`timescale 1ns/1ps
module tb_jt12_cmd_seq;

  localparam int AW = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cen = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [18:0] cmd_data = '0;
  logic [7:0]  din;
  logic [1:0]  addr;
  logic        cs_n;
  logic        wr_n;
  logic        psg_wr_n;
  logic [7:0]  dout = 8'h00;
  logic        snd_sample = 1'b0;
  logic        idle;
  logic        timeout;
  logic [AW:0] level;

  int n_checks  = 0;
  int n_pass    = 0;
  int n_overlap = 0;

  localparam logic [18:0] NOP = {2'b11, 17'h0};

  jt12_cmd_seq #(.AW(AW), .WR_CYC(2), .BUSY_TO(255)) dut (
    .clk        (clk),
    .rst        (rst),
    .cen        (cen),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_data   (cmd_data),
    .din        (din),
    .addr       (addr),
    .cs_n       (cs_n),
    .wr_n       (wr_n),
    .psg_wr_n   (psg_wr_n),
    .dout       (dout),
    .snd_sample (snd_sample),
    .idle       (idle),
    .timeout    (timeout),
    .level      (level)
  );

  always #5 clk = ~clk;

  // The two write strobes must never be low together.
  always @(negedge clk) begin
    if (!rst && !wr_n && !psg_wr_n) n_overlap++;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("check %s got %0h ok", tag, got);
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [18:0] c, input string tag);
    logic done;
    done = 1'b0;
    cmd_valid = 1'b1;
    cmd_data  = c;
    for (int n = 0; n < 100 && !done; n++) begin
      if (cmd_ready) done = 1'b1;
      tick();
    end
    cmd_valid = 1'b0;
    if (!done) check_eq({tag, "_accept"}, 32'(done), 1);
    $display("push %s data=%05h level=%0d", tag, c, level);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (!idle && n < 1000) begin
      tick();
      n++;
    end
    check_eq(tag, 32'(idle), 1);
  endtask

  initial begin
    logic [7:0] tr_wr, tr_cs, tr_a, tr_idle;
    logic [3:0] tr_psg, tr_pcs;
    logic [7:0] din_a, din_d, din_p1, din_p3;
    logic       addr_hi, busy_ok, idle_p4;
    int         n, rises, got_rises;

    // Reset state
    rst = 1'b1;
    cen = 1'b0;
    tick();
    tick();
    check_eq("rst_cs_n", 32'(cs_n), 1);
    check_eq("rst_wr_n", 32'(wr_n), 1);
    check_eq("rst_psg_wr_n", 32'(psg_wr_n), 1);
    check_eq("rst_din", 32'(din), 0);
    check_eq("rst_addr", 32'(addr), 0);
    check_eq("rst_level", 32'(level), 0);
    check_eq("rst_cmd_ready", 32'(cmd_ready), 0);
    check_eq("rst_timeout", 32'(timeout), 0);
    check_eq("rst_idle", 32'(idle), 1);
    rst = 1'b0;
    tick();

    // FM write, busy clear
    dout = 8'h00;
    cen  = 1'b1;
    push({2'b00, 1'b0, 8'h28, 8'hF0}, "fm");
    tr_wr = '0; tr_cs = '0; tr_a = '0; tr_idle = '0;
    din_a = '0; din_d = '0; addr_hi = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      tick();
      tr_wr[j-1]   = wr_n;
      tr_cs[j-1]   = cs_n;
      tr_a[j-1]    = addr[0];
      tr_idle[j-1] = idle;
      addr_hi      = addr_hi | addr[1];
      if (j == 2) din_a = din;
      if (j == 5) din_d = din;
    end
    check_eq("fm_wr_n_trace", 32'(tr_wr), 'hC9);
    check_eq("fm_cs_n_trace", 32'(tr_cs), 'hC8);
    check_eq("fm_addr0_trace", 32'(tr_a), 'hF0);
    check_eq("fm_idle_trace", 32'(tr_idle), 'h80);
    check_eq("fm_din_reg", 32'(din_a), 'h28);
    check_eq("fm_din_val", 32'(din_d), 'hF0);
    check_eq("fm_part", 32'(addr_hi), 0);

    // Busy for 10 polls, then released
    dout = 8'h80;
    push({2'b00, 1'b1, 8'h30, 8'h55}, "fm_busy");
    busy_ok = 1'b1;
    for (int j = 0; j <= 10; j++) begin
      tick();
      if (wr_n !== 1'b1 || cs_n !== 1'b0) busy_ok = 1'b0;
    end
    check_eq("busy_poll_hold", 32'(busy_ok), 1);
    dout = 8'h00;
    tick();
    check_eq("busy_awr_wr_n", 32'(wr_n), 0);
    check_eq("busy_awr_addr", 32'(addr), 2);
    check_eq("busy_awr_din", 32'(din), 'h30);
    wait_idle("busy_done");
    check_eq("busy_no_timeout", 32'(timeout), 0);

    // Busy stuck: timeout after 255 polls
    dout = 8'h80;
    push({2'b00, 1'b0, 8'h2B, 8'h80}, "fm_stuck");
    tick();
    n = 0;
    while (wr_n && n < 400) begin
      tick();
      n++;
    end
    check_eq("timeout_polls", 32'(n), 255);
    check_eq("timeout_set", 32'(timeout), 1);
    wait_idle("timeout_write_done");
    dout = 8'h00;
    check_eq("timeout_sticky", 32'(timeout), 1);

    // PSG write
    push({2'b01, 1'b0, 8'h00, 8'h9F}, "psg");
    tr_psg = '0; tr_pcs = '0; din_p1 = '0; din_p3 = '0; idle_p4 = 1'b0;
    for (int j = 1; j <= 4; j++) begin
      tick();
      tr_psg[j-1] = psg_wr_n;
      tr_pcs[j-1] = cs_n;
      if (j == 1) din_p1 = din;
      if (j == 3) din_p3 = din;
      if (j == 4) idle_p4 = idle;
    end
    check_eq("psg_wr_n_trace", 32'(tr_psg), 'hC);
    check_eq("psg_cs_n_trace", 32'(tr_pcs), 'hF);
    check_eq("psg_din_strobe", 32'(din_p1), 'h9F);
    check_eq("psg_din_release", 32'(din_p3), 'h9F);
    check_eq("psg_idle", 32'(idle_p4), 1);

    // WAIT 3 then FM: address strobe only after the 3rd sample edge
    cen = 1'b0;
    push({2'b10, 1'b0, 16'd3}, "wait3");
    push({2'b00, 1'b0, 8'hA4, 8'h22}, "fm_after_wait3");
    check_eq("wait3_level", 32'(level), 2);
    cen = 1'b1;
    rises = 0;
    got_rises = 0;
    for (int c = 0; c < 200; c++) begin
      snd_sample = ((c % 12) >= 5) && ((c % 12) < 7);
      if ((c % 12) == 5) rises++;
      tick();
      if (!wr_n) begin
        got_rises = rises;
        break;
      end
    end
    snd_sample = 1'b0;
    check_eq("wait3_edges_before_strobe", 32'(got_rises), 3);
    check_eq("wait3_strobe_din", 32'(din), 'hA4);
    wait_idle("wait3_done");

    // WAIT 0 adds one IDLE cycle only
    cen = 1'b0;
    push({2'b10, 1'b0, 16'd0}, "wait0");
    push({2'b00, 1'b0, 8'hB4, 8'hC0}, "fm_after_wait0");
    cen = 1'b1;
    n = 0;
    while (wr_n && n < 50) begin
      tick();
      n++;
    end
    check_eq("wait0_cycles_to_strobe", 32'(n), 3);
    wait_idle("wait0_done");

    // FIFO limits
    cen = 1'b0;
    for (int i = 0; i < 16; i++) push(NOP, "nop");
    check_eq("full_level", 32'(level), 16);
    check_eq("full_ready", 32'(cmd_ready), 0);
    cmd_valid = 1'b1;
    cmd_data  = {2'b00, 1'b1, 8'hB6, 8'hC0};
    tick();
    check_eq("full_17th_held", 32'(level), 16);
    cen = 1'b1;
    tick();
    check_eq("pop_at_full", 32'(level), 15);
    tick();
    check_eq("push_pop_same_cycle", 32'(level), 15);
    cmd_valid = 1'b0;
    $display("push fifo_17th data=%05h level=%0d", cmd_data, level);
    wait_idle("fifo_drain");
    check_eq("fifo_drain_level", 32'(level), 0);

    // Reset in the middle of the data strobe
    cen = 1'b0;
    push({2'b00, 1'b0, 8'h40, 8'h7F}, "fm_rst");
    push(NOP, "nop_rst1");
    push(NOP, "nop_rst2");
    cen = 1'b1;
    n = 0;
    while (!(wr_n == 1'b0 && addr[0] == 1'b1) && n < 50) begin
      tick();
      n++;
    end
    check_eq("dwr_din", 32'(din), 'h7F);
    cen = 1'b0;
    tick();
    tick();
    check_eq("cen_hold_wr_n", 32'(wr_n), 0);
    check_eq("cen_hold_addr", 32'(addr), 1);
    check_eq("level_mid_write", 32'(level), 2);
    rst = 1'b1;
    tick();
    check_eq("rst_dwr_wr_n", 32'(wr_n), 1);
    check_eq("rst_dwr_cs_n", 32'(cs_n), 1);
    check_eq("rst_dwr_level", 32'(level), 0);
    check_eq("rst_dwr_ready", 32'(cmd_ready), 0);
    check_eq("rst_dwr_timeout", 32'(timeout), 0);
    check_eq("rst_dwr_din", 32'(din), 0);
    rst = 1'b0;
    cen = 1'b1;
    tick();
    tick();
    check_eq("post_rst_level", 32'(level), 0);
    check_eq("post_rst_idle", 32'(idle), 1);
    check_eq("post_rst_wr_n", 32'(wr_n), 1);

    check_eq("strobe_overlap", 32'(n_overlap), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
